weight_bank: RTL and testbench

//  Weight store serving the network datapath. Holds DEPTH rows of CLASSES signed 8-bit weights,
//  one row per input pixel. Answers row reads during forward prop and applies per-row weight

---
 rtl/weight_bank_if.sv | 33 +++
 rtl/weight_bank.sv | 124 ++++++++++++
 tb/tb_weight_bank.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/weight_bank_if.sv
// Request/response bundle between the network datapath (master) and the weight bank (slave).
// Handshake: rd_en/upd_en/ld_en are one-cycle requests taken on any rising edge with ready==1
// (no backpressure once ready); rd_valid pulses for one cycle while weights carries the row.
interface weight_bank_if #(
  parameter int DEPTH   = 256,
  parameter int CLASSES = 10
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = CLASSES * 8;

  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          upd_en;
  logic [AW-1:0] upd_addr;
  logic [W-1:0]  delta;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;
  logic [W-1:0]  weights;
  logic          rd_valid;
  logic          ready;
  logic          drop_err;

  modport master (
    output rd_en, rd_addr, upd_en, upd_addr, delta, ld_en, ld_addr, ld_data,
    input  weights, rd_valid, ready, drop_err
  );

  modport slave (
    input  rd_en, rd_addr, upd_en, upd_addr, delta, ld_en, ld_addr, ld_data,
    output weights, rd_valid, ready, drop_err
  );
endinterface

// File: rtl/weight_bank.sv
// Row-organised signed 8-bit weight store: single-cycle reads, host row loads and a two-stage
// saturating read-modify-write update pipe, zero-filled by a CLEAR sweep after every reset.
module weight_bank #(
  parameter int DEPTH   = 256,
  parameter int CLASSES = 10
) (
  input  logic         clk,
  input  logic         reset,
  weight_bank_if.slave bus,
  output logic         state_dbg
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = CLASSES * 8;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_ptr;
  logic [W-1:0]  mem [DEPTH];

  logic          is_ready;
  logic          rd_ok, upd_ok, ld_ok;
  logic          rd_go, upd_go, ld_go, drop_set;

  logic          s2_valid;
  logic [AW-1:0] s2_addr;
  logic [W-1:0]  s2_old, s2_delta, s2_new;
  logic [W-1:0]  rd_row, upd_row;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {a[7], a} + {b[7], b};
    if (s[8] != s[7]) return s[8] ? 8'h80 : 8'h7F;
    return s[7:0];
  endfunction

  // Range checks only matter when DEPTH leaves unused address codes.
  generate
    if (DEPTH == (1 << AW)) begin : g_pow2
      assign rd_ok  = 1'b1;
      assign upd_ok = 1'b1;
      assign ld_ok  = 1'b1;
    end else begin : g_range
      assign rd_ok  = (32'(bus.rd_addr)  < DEPTH);
      assign upd_ok = (32'(bus.upd_addr) < DEPTH);
      assign ld_ok  = (32'(bus.ld_addr)  < DEPTH);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    is_ready  = 1'b0;
    case (state)
      CLEAR:   if (clr_ptr == AW'(DEPTH - 1)) state_nxt = READY;
      READY:   is_ready = 1'b1;
      default: state_nxt = CLEAR;
    endcase
  end

  assign bus.ready = is_ready;
  assign state_dbg = state;

  assign rd_go    = is_ready & bus.rd_en  & rd_ok;
  assign upd_go   = is_ready & bus.upd_en & upd_ok;
  assign ld_go    = is_ready & bus.ld_en  & ld_ok;
  assign drop_set = (bus.rd_en  & ~(is_ready & rd_ok)) |
                    (bus.upd_en & ~(is_ready & upd_ok)) |
                    (bus.ld_en  & ~(is_ready & ld_ok));

  always_comb begin
    s2_new = '0;
    for (int i = 0; i < CLASSES; i++)
      s2_new[8*i +: 8] = sat_add(s2_old[8*i +: 8], s2_delta[8*i +: 8]);
  end

  // Forwarding priority: a same-cycle load beats the S2 write, which beats the array.
  always_comb begin
    rd_row = mem[bus.rd_addr];
    if (s2_valid && s2_addr == bus.rd_addr) rd_row = s2_new;
    if (ld_go && bus.ld_addr == bus.rd_addr) rd_row = bus.ld_data;
    upd_row = mem[bus.upd_addr];
    if (s2_valid && s2_addr == bus.upd_addr) upd_row = s2_new;
    if (ld_go && bus.ld_addr == bus.upd_addr) upd_row = bus.ld_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_ptr      <= '0;
      s2_valid     <= 1'b0;
      s2_addr      <= '0;
      s2_old       <= '0;
      s2_delta     <= '0;
      bus.weights  <= '0;
      bus.rd_valid <= 1'b0;
      bus.drop_err <= 1'b0;
    end else begin
      if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
      s2_valid <= upd_go;
      if (upd_go) begin
        s2_addr  <= bus.upd_addr;
        s2_delta <= bus.delta;
        s2_old   <= upd_row;
      end
      bus.rd_valid <= rd_go;
      if (rd_go) bus.weights <= rd_row;
      if (drop_set) bus.drop_err <= 1'b1;
    end
  end

  // Array has no reset of its own; the CLEAR sweep rewrites every row.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else begin
      if (s2_valid && !(ld_go && bus.ld_addr == s2_addr)) mem[s2_addr] <= s2_new;
      if (ld_go) mem[bus.ld_addr] <= bus.ld_data;
    end
  end
endmodule

// File: tb/tb_weight_bank.sv
// Directed bench for weight_bank: reads push expected rows into a queue, a negedge monitor
// pops and compares them on every rd_valid; status outputs are checked inline.
module tb_weight_bank;
  localparam int DEPTH   = 256;
  localparam int CLASSES = 10;
  localparam int AW      = 8;
  localparam int W       = CLASSES * 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic state_dbg;

  weight_bank_if #(.DEPTH(DEPTH), .CLASSES(CLASSES)) bus ();

  weight_bank #(.DEPTH(DEPTH), .CLASSES(CLASSES)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] rep(input logic [7:0] b);
    return {CLASSES{b}};
  endfunction

  function automatic logic [W-1:0] lanes(input int mult);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < CLASSES; i++) r[8*i +: 8] = 8'(i * mult);
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_in();
    bus.rd_en  = 1'b0;
    bus.upd_en = 1'b0;
    bus.ld_en  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic set_rd(input logic [AW-1:0] a, input logic [W-1:0] e);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc);
  endtask

  task automatic set_upd(input logic [AW-1:0] a, input logic [W-1:0] d);
    bus.upd_en   = 1'b1;
    bus.upd_addr = a;
    bus.delta    = d;
  endtask

  task automatic set_ld(input logic [AW-1:0] a, input logic [W-1:0] row);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = row;
  endtask

  task automatic wait_ready(output int n, input int idle_after);
    n = 0;
    while (!bus.ready && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      if (n == idle_after) idle_in();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    int           c;
    if (reset && bus.rd_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected: rd_valid=1 weights=%h, expected no read response", bus.weights);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        if (bus.weights !== e || cyc != c + 1) begin
          n_bad++;
          $display("FAIL rd_data: got %h at cycle %0d, expected %h at cycle %0d",
                   bus.weights, cyc, e, c + 1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    idle_in();
    bus.rd_addr  = '0;
    bus.upd_addr = '0;
    bus.delta    = '0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;

    #2 reset = 1'b0;
    #10;
    check("reset_ready",    W'(bus.ready),    '0);
    check("reset_rd_valid", W'(bus.rd_valid), '0);
    check("reset_weights",  bus.weights,      '0);
    check("reset_drop_err", W'(bus.drop_err), '0);

    // T1: zero-fill timing and contents
    @(posedge clk);
    #1 reset = 1'b1;
    wait_ready(n, 0);
    check("clear_cycles", W'(n), W'(256));
    check("state_ready",  W'(state_dbg), W'(1));
    check("drop_err_idle_clear", W'(bus.drop_err), '0);
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(AW'(a), '0);
      step();
    end

    // T2: load then read
    set_ld(5, rep(8'h10)); step();
    set_rd(5, rep(8'h10)); step();

    // T3: back-to-back updates accumulate
    set_upd(5, rep(8'h05)); step();
    set_upd(5, rep(8'h05)); step();
    step();
    set_rd(5, rep(8'h1A)); step();

    // T4: saturation at both rails and negative delta
    set_ld(7, rep(8'h7C)); step();
    set_ld(8, rep(8'h84)); step();
    set_ld(9, rep(8'h20)); step();
    set_upd(7, rep(8'h10)); step();
    set_upd(8, rep(8'hF0)); step();
    set_upd(9, rep(8'hE0)); step();
    step();
    set_rd(7, rep(8'h7F)); step();
    set_rd(8, rep(8'h80)); step();
    set_rd(9, rep(8'h00)); step();

    // per-lane independence: lane i = i, delta i -> 2i
    set_ld(10, lanes(1)); step();
    set_upd(10, lanes(1)); step();
    step();
    set_rd(10, lanes(2)); step();

    // T5: read alongside S1 sees old row, read during S2 sees forwarded row
    set_ld(3, rep(8'h10)); step();
    set_upd(3, rep(8'h01)); set_rd(3, rep(8'h10)); step();
    set_rd(3, rep(8'h11)); step();

    // load + update + read on one row in one cycle
    set_ld(11, rep(8'h20)); set_upd(11, rep(8'h03)); set_rd(11, rep(8'h20)); step();
    step();
    set_rd(11, rep(8'h23)); step();

    // load in the S2 cycle of the same row drops the update write
    set_upd(12, rep(8'h01)); step();
    set_ld(12, rep(8'h40)); step();
    set_rd(12, rep(8'h40)); step();

    // T6: reset mid-update with a read response in flight
    set_ld(13, rep(8'h55)); step();
    bus.rd_en = 1'b1; bus.rd_addr = 13;
    set_upd(5, rep(8'h01));
    @(posedge clk);
    #1 idle_in();
    reset = 1'b0;
    #1;
    check("midrst_ready",    W'(bus.ready),    '0);
    check("midrst_rd_valid", W'(bus.rd_valid), '0);
    check("midrst_weights",  bus.weights,      '0);
    check("midrst_state",    W'(state_dbg),    '0);
    @(posedge clk);
    #1 reset = 1'b1;
    // requests during CLEAR are all dropped
    bus.rd_en = 1'b1; bus.rd_addr = 5;
    set_upd(6, rep(8'h01));
    set_ld(6, rep(8'h77));
    wait_ready(n, 3);
    check("clear_cycles_2",  W'(n), W'(256));
    check("drop_err_sticky", W'(bus.drop_err), W'(1));
    set_rd(5, '0);  step();
    set_rd(6, '0);  step();
    set_rd(13, '0); step();
    set_rd(12, '0); step();
    check("drop_err_held", W'(bus.drop_err), W'(1));
    repeat (4) step();
    check("queue_drained", W'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
